// File: rtl/piso_serializer_pkg.sv
// piso_pkg: state encodings and counter-width helper for the PISO serializer
package piso_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_e;

   function automatic int cnt_w(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// piso_serializer_if: parallel load handshake plus serial output bus
interface piso_serializer_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             sout_en;
   logic             sout;
   logic             sout_valid;
   logic             sof;
   logic             eof;
   logic             busy;

   modport master (
      output din, din_valid, sout_en,
      input  din_ready, sout, sout_valid, sof, eof, busy
   );

   modport slave (
      input  din, din_valid, sout_en,
      output din_ready, sout, sout_valid, sof, eof, busy
   );

endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: shifts a captured parallel word out one bit per sout_en, with optional even parity
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit PARITY_EN = 1'b0
) (
   input logic                clk,
   input logic                rst,
   piso_serializer_if.slave   bus_if
);

   localparam int CW = cnt_w(WIDTH);

   if (WIDTH < 2) begin : g_width_check
      $error("piso_serializer: WIDTH must be >= 2");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             par_q, par_d;
   logic             head, last, consume;

   assign head    = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
   assign last    = cnt_q == CW'(WIDTH - 1);
   assign consume = (state_q != IDLE) && bus_if.sout_en;

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      par_d   = par_q;
      if (state_q == IDLE && bus_if.din_valid) begin
         sh_d    = bus_if.din;
         par_d   = ^bus_if.din;
         cnt_d   = '0;
         state_d = SHIFT;
      end else if (consume && state_q == SHIFT) begin
         sh_d    = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
         cnt_d   = last ? '0 : cnt_q + 1'b1;
         state_d = last ? (PARITY_EN ? PARITY : IDLE) : SHIFT;
      end else if (consume) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sh_q    <= '0;
         cnt_q   <= '0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         par_q   <= par_d;
      end
   end

   // every output decodes registered state only; no din/sout_en feedthrough
   assign bus_if.din_ready  = state_q == IDLE;
   assign bus_if.busy       = state_q != IDLE;
   assign bus_if.sout_valid = state_q != IDLE;
   assign bus_if.sout       = (state_q == SHIFT) ? head : (state_q == PARITY) ? par_q : 1'b0;
   assign bus_if.sof        = state_q == SHIFT && cnt_q == '0;
   assign bus_if.eof        = PARITY_EN ? state_q == PARITY : state_q == SHIFT && last;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks of MSB-first and LSB-first-with-parity serializers
module tb_piso_serializer;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   piso_serializer_if #(.WIDTH(4)) bus_a ();
   piso_serializer_if #(.WIDTH(4)) bus_b ();

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) dut_a (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus_a)
   );

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .PARITY_EN(1'b1)) dut_b (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step;
      @(negedge clk);
   endtask

   task automatic idle_a(input string tag);
      chk({tag, "_ready"}, bus_a.din_ready, 1);
      chk({tag, "_valid"}, bus_a.sout_valid, 0);
      chk({tag, "_busy"}, bus_a.busy, 0);
      chk({tag, "_sout"}, bus_a.sout, 0);
      chk({tag, "_sof"}, bus_a.sof, 0);
      chk({tag, "_eof"}, bus_a.eof, 0);
   endtask

   task automatic frame_a(input logic [3:0] w, input int stall_at, input int stall_n);
      logic exp;
      bus_a.din       = w;
      bus_a.din_valid = 1'b1;
      bus_a.sout_en   = 1'b1;
      step;
      bus_a.din_valid = 1'b0;
      bus_a.din       = ~w;
      for (int i = 0; i < 4; i++) begin
         exp = w[3-i];
         chk("a_sout", bus_a.sout, exp);
         chk("a_valid", bus_a.sout_valid, 1);
         chk("a_sof", bus_a.sof, i == 0);
         chk("a_eof", bus_a.eof, i == 3);
         chk("a_ready", bus_a.din_ready, 0);
         if (i == stall_at) begin
            bus_a.sout_en = 1'b0;
            repeat (stall_n) begin
               step;
               chk("a_hold_sout", bus_a.sout, exp);
               chk("a_hold_eof", bus_a.eof, i == 3);
               chk("a_hold_busy", bus_a.busy, 1);
            end
            bus_a.sout_en = 1'b1;
         end
         step;
      end
      idle_a("a_done");
   endtask

   task automatic frame_b(input logic [3:0] w);
      logic [4:0] bits;
      bits = {^w, w[3], w[2], w[1], w[0]};
      bus_b.din       = w;
      bus_b.din_valid = 1'b1;
      bus_b.sout_en   = 1'b1;
      step;
      bus_b.din_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("b_sout", bus_b.sout, bits[i]);
         chk("b_valid", bus_b.sout_valid, 1);
         chk("b_sof", bus_b.sof, i == 0);
         chk("b_eof", bus_b.eof, i == 4);
         step;
      end
      chk("b_done_ready", bus_b.din_ready, 1);
      chk("b_done_valid", bus_b.sout_valid, 0);
      chk("b_done_eof", bus_b.eof, 0);
   endtask

   initial begin
      logic [3:0] seq_a;
      logic [3:0] seq_5;
      n_chk = 0;
      n_err = 0;
      rst = 1'b1;
      bus_a.din = '0; bus_a.din_valid = 1'b0; bus_a.sout_en = 1'b0;
      bus_b.din = '0; bus_b.din_valid = 1'b0; bus_b.sout_en = 1'b0;
      step;
      step;
      rst = 1'b0;
      idle_a("rst");
      chk("rst_b_ready", bus_b.din_ready, 1);
      chk("rst_b_valid", bus_b.sout_valid, 0);
      for (int i = 0; i < 3; i++) begin
         step;
         idle_a("idle");
      end

      // basic MSB-first frame, then the same word with a 3-cycle stall on bit 1
      frame_a(4'b1011, -1, 0);
      frame_a(4'b1011, 1, 3);

      // LSB-first with parity, odd and even popcount
      frame_b(4'b0111);
      frame_b(4'b0110);

      // back-to-back words with din_valid held high
      seq_a = 4'hA;
      seq_5 = 4'h5;
      bus_a.din       = seq_a;
      bus_a.din_valid = 1'b1;
      bus_a.sout_en   = 1'b1;
      step;
      bus_a.din = seq_5;
      for (int i = 0; i < 4; i++) begin
         chk("bb1_sout", bus_a.sout, seq_a[3-i]);
         chk("bb1_ready", bus_a.din_ready, 0);
         chk("bb1_eof", bus_a.eof, i == 3);
         step;
      end
      chk("bb_gap_ready", bus_a.din_ready, 1);
      chk("bb_gap_valid", bus_a.sout_valid, 0);
      step;
      bus_a.din_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("bb2_sout", bus_a.sout, seq_5[3-i]);
         chk("bb2_sof", bus_a.sof, i == 0);
         chk("bb2_ready", bus_a.din_ready, 0);
         step;
      end
      idle_a("bb_end");

      // reset mid-frame on bit 2, with din_valid high during reset
      bus_a.din       = 4'b1100;
      bus_a.din_valid = 1'b1;
      step;
      bus_a.din_valid = 1'b0;
      chk("rm_b0", bus_a.sout, 1);
      step;
      chk("rm_b1", bus_a.sout, 1);
      step;
      chk("rm_b2", bus_a.sout, 0);
      rst             = 1'b1;
      bus_a.din_valid = 1'b1;
      step;
      rst             = 1'b0;
      bus_a.din_valid = 1'b0;
      idle_a("rm_abort");
      step;
      idle_a("rm_after");
      frame_a(4'b0001, -1, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Downstream stage of the 4-bit parallel-in/parallel-out register: takes its registered parallel word and shifts it out one bit at a time.
- Uses a valid/ready load handshake and a per-bit shift enable, so a slow serial link can pace it.
- Optional trailing even-parity bit.
- Frame markers (sof/eof) let the link layer delimit words.

Parameters:
- WIDTH, 4, parallel word width; must be >= 2 (elaboration-time check).
- MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first.
- PARITY_EN, 0, 1 = append one even-parity bit after the data bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- din  in  WIDTH  parallel word (from PIPO q).
- din_valid  in  1  din holds a word to send.
- din_ready  out  1  block can accept a word this cycle.
- sout_en  in  1  downstream consumes the current serial bit this cycle.
- sout  out  1  current serial bit.
- sout_valid  out  1  sout carries a frame bit.
- sof  out  1  current bit is the first bit of the frame.
- eof  out  1  current bit is the last bit of the frame (parity bit if PARITY_EN).
- busy  out  1  frame in progress (state != IDLE).

Behaviour:
- Interface:
  - One clock, clk; reset rst is synchronous and active-high.
  - rst has priority over all other inputs.
- Reset values:
  - State = IDLE; shift register, bit counter and parity register = 0.
  - sout = 0, sout_valid = 0, sof = 0, eof = 0, busy = 0, din_ready = 1.
- States:
  - IDLE: din_ready = 1; sout_valid = 0; sout = 0.
  - SHIFT: sends data bits; bit counter cnt runs 0..WIDTH-1.
  - PARITY: sends one parity bit. Only reachable when PARITY_EN = 1.
- Load:
  - On an edge with state == IDLE and din_valid = 1: capture din into the shift register, parity register <= ^din, cnt <= 0, state -> SHIFT.
  - The first bit appears on sout in the cycle after the load edge (1-cycle latency).
- Outputs:
  - sout is taken from the shift register head: bit WIDTH-1 if MSB_FIRST, bit 0 otherwise. In PARITY, sout = parity register.
  - All outputs are decoded from registers only; there is no combinational path from din or sout_en to any output.
  - din_ready = (state == IDLE). It does not depend on din_valid.
- Advance:
  - A bit is consumed on an edge where sout_valid = 1 and sout_en = 1. The shift register shifts toward the head, filling with 0, and cnt increments.
  - With sout_en = 0, sout, sof, eof and the state hold indefinitely.
- Transitions:
  - SHIFT with cnt == WIDTH-1 consumed -> PARITY if PARITY_EN, else IDLE.
  - PARITY consumed -> IDLE.
- Markers:
  - sof = (state == SHIFT && cnt == 0).
  - eof = (PARITY_EN ? state == PARITY : state == SHIFT && cnt == WIDTH-1).
- Throughput:
  - One idle cycle between frames: the IDLE cycle in which the next word is loaded.
  - Max rate is one word per WIDTH + PARITY_EN + 1 cycles.
- Boundary conditions:
  - din_valid while busy: ignored. din_ready = 0 and upstream must hold its word.
  - din changing while busy: no effect, because the word was captured at load.
  - rst mid-frame: the frame is aborted at that edge and all outputs return to reset values the next cycle. eof is never asserted for an aborted frame.
  - rst and din_valid together: reset wins and nothing is loaded.
  - Counter width: clog2(WIDTH) bits, no wrap beyond WIDTH-1.

Decomposition:
- Shared include/package piso_pkg holds:
  - State encodings: IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2.
  - Counter-width helper function (clog2).
- Single module; no sub-module. The counter and shifter are small enough to keep inline.

Test Plan:
- Reset, then idle:
  - rst = 1 for 2 cycles, then released with din_valid = 0 -> din_ready = 1, sout_valid = 0, busy = 0 on every cycle.
- Basic MSB-first frame (WIDTH = 4, MSB_FIRST = 1, PARITY_EN = 0):
  - din = 4'b1011, din_valid pulse, sout_en = 1 -> sout = 1, 0, 1, 1 on the 4 following cycles.
  - sof on bit 0, eof on bit 3, din_ready = 1 again on the next cycle.
- Stall:
  - Same frame with sout_en = 0 for 3 cycles after bit 1 -> sout holds 0 for those 3 cycles, then 1, 1.
  - 4 consumed bits total; eof only on the final consumed bit.
- LSB-first with parity (MSB_FIRST = 0, PARITY_EN = 1):
  - din = 4'b0111 -> sout = 1, 1, 1, 0, then parity bit 1; eof only on the parity bit.
  - Repeat with din = 4'b0110 -> parity bit 0.
- Back-pressure and back-to-back:
  - Hold din_valid = 1 continuously with words 4'hA then 4'h5 -> din_ready = 0 during the frame.
  - Second word loads in the IDLE cycle; bits are 1, 0, 1, 0, idle, 0, 1, 0, 1.
- Reset mid-frame:
  - Assert rst after bit 2 of 4'b1100 -> next cycle sout_valid = 0, busy = 0, din_ready = 1, no eof.
  - A new word 4'b0001 then serializes cleanly as 0, 0, 0, 1.
